// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALUSystem control sequencer: states, opcodes,
// datapath function/select codes and the control output bundle.
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_FETCH_L = 3'd1,
    S_FETCH_H = 3'd2,
    S_DECODE  = 3'd3,
    S_EXEC    = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_ADD   = 4'h1,
    OP_SUB   = 4'h2,
    OP_AND   = 4'h3,
    OP_OR    = 4'h4,
    OP_XOR   = 4'h5,
    OP_NOT   = 4'h6,
    OP_LDI   = 4'h7,
    OP_LD    = 4'h8,
    OP_ST    = 4'h9,
    OP_BRA   = 4'hA,
    OP_BEQ   = 4'hB,
    OP_HLT   = 4'hC,
    OP_UND_D = 4'hD,
    OP_UND_E = 4'hE,
    OP_UND_F = 4'hF
  } opcode_t;

  localparam logic [3:0] ALU_PASS_A = 4'h0;
  localparam logic [3:0] ALU_NOT_A  = 4'h2;
  localparam logic [3:0] ALU_ADD    = 4'h4;
  localparam logic [3:0] ALU_SUB    = 4'h6;
  localparam logic [3:0] ALU_AND    = 4'h7;
  localparam logic [3:0] ALU_OR     = 4'h8;
  localparam logic [3:0] ALU_XOR    = 4'h9;

  localparam logic [1:0] FUN_DEC  = 2'b00;
  localparam logic [1:0] FUN_INC  = 2'b01;
  localparam logic [1:0] FUN_LOAD = 2'b10;
  localparam logic [1:0] FUN_CLR  = 2'b11;

  localparam logic [3:0] REG_R1  = 4'b1000;
  localparam logic [3:0] REG_R2  = 4'b0100;
  localparam logic [3:0] REG_R3  = 4'b0010;
  localparam logic [3:0] REG_R4  = 4'b0001;
  localparam logic [3:0] REG_ALL = 4'b1111;

  localparam logic [2:0] OUT_R1 = 3'b100;
  localparam logic [2:0] OUT_R2 = 3'b101;
  localparam logic [2:0] OUT_R3 = 3'b110;
  localparam logic [2:0] OUT_R4 = 3'b111;

  localparam logic [1:0] ARF_SEL_PC = 2'b00;
  localparam logic [1:0] ARF_SEL_AR = 2'b10;
  localparam logic [1:0] ARF_SEL_SP = 2'b11;

  localparam logic [3:0] ARF_EN_PC  = 4'b1000;
  localparam logic [3:0] ARF_EN_AR  = 4'b0100;
  localparam logic [3:0] ARF_EN_SP  = 4'b0010;
  localparam logic [3:0] ARF_EN_ALL = ARF_EN_PC | ARF_EN_AR | ARF_EN_SP;

  localparam logic [1:0] MUX_ALU = 2'b00;
  localparam logic [1:0] MUX_MEM = 2'b01;
  localparam logic [1:0] MUX_IMM = 2'b10;
  localparam logic [1:0] MUX_ARF = 2'b11;

  typedef struct packed {
    logic [2:0] rf_outa_sel;
    logic [2:0] rf_outb_sel;
    logic [1:0] rf_fun_sel;
    logic [3:0] rf_r_sel;
    logic [3:0] rf_t_sel;
    logic [3:0] alu_fun_sel;
    logic [1:0] arf_outa_sel;
    logic [1:0] arf_outb_sel;
    logic [1:0] arf_fun_sel;
    logic [3:0] arf_r_sel;
    logic       ir_lh;
    logic       ir_enable;
    logic [1:0] ir_fun_sel;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] mux_a_sel;
    logic [1:0] mux_b_sel;
    logic       mux_c_sel;
  } ctrl_t;

  function automatic logic [3:0] alu_fun(input opcode_t op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      OP_NOT:  return ALU_NOT_A;
      default: return ALU_PASS_A;
    endcase
  endfunction

  function automatic logic [3:0] reg_onehot(input logic [1:0] code);
    case (code)
      2'd0:    return REG_R1;
      2'd1:    return REG_R2;
      2'd2:    return REG_R3;
      default: return REG_R4;
    endcase
  endfunction

  function automatic logic [2:0] reg_outsel(input logic [1:0] code);
    return {1'b1, code};
  endfunction

  function automatic logic is_undef(input opcode_t op);
    return (op == OP_UND_D) || (op == OP_UND_E) || (op == OP_UND_F);
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational control decode: (state, IR, Z) -> full ALUSystem control bundle.
// force_idle holds every write enable off, e.g. while Reset is high.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  state_t      state,
  input  logic        force_idle,
  input  logic [15:0] ir,
  input  logic        flag_z,
  output ctrl_t       ctl
);

  opcode_t    op;
  logic [1:0] dst;
  logic [1:0] src1;
  logic [1:0] src2;
  logic       unused_ir_bits;

  assign op   = opcode_t'(ir[15:12]);
  assign dst  = ir[11:10];
  assign src1 = ir[9:8];
  assign src2 = ir[7:6];
  // The immediate reaches the datapath through IR_Out directly.
  assign unused_ir_bits = ^ir[5:0];

  always_comb begin
    ctl        = '0;
    ctl.mem_cs = 1'b1;
    if (!force_idle) begin
      case (state)
        S_INIT: begin
          ctl.rf_fun_sel  = FUN_CLR;
          ctl.rf_r_sel    = REG_ALL;
          ctl.rf_t_sel    = REG_ALL;
          ctl.arf_fun_sel = FUN_CLR;
          ctl.arf_r_sel   = ARF_EN_ALL;
        end
        S_FETCH_L, S_FETCH_H: begin
          ctl.arf_outb_sel = ARF_SEL_PC;
          ctl.mem_cs       = 1'b0;
          ctl.ir_enable    = 1'b1;
          ctl.ir_lh        = (state == S_FETCH_H);
          ctl.ir_fun_sel   = FUN_LOAD;
          ctl.arf_r_sel    = ARF_EN_PC;
          ctl.arf_fun_sel  = FUN_INC;
        end
        S_EXEC: begin
          case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
              ctl.rf_outa_sel = reg_outsel(src1);
              ctl.rf_outb_sel = reg_outsel(src2);
              ctl.alu_fun_sel = alu_fun(op);
              ctl.mux_a_sel   = MUX_ALU;
              ctl.rf_fun_sel  = FUN_LOAD;
              ctl.rf_r_sel    = reg_onehot(dst);
            end
            OP_LDI: begin
              ctl.mux_a_sel  = MUX_IMM;
              ctl.rf_fun_sel = FUN_LOAD;
              ctl.rf_r_sel   = reg_onehot(dst);
            end
            OP_LD: begin
              ctl.arf_outb_sel = ARF_SEL_AR;
              ctl.mem_cs       = 1'b0;
              ctl.mux_a_sel    = MUX_MEM;
              ctl.rf_fun_sel   = FUN_LOAD;
              ctl.rf_r_sel     = reg_onehot(dst);
            end
            OP_ST: begin
              ctl.arf_outb_sel = ARF_SEL_AR;
              ctl.rf_outa_sel  = reg_outsel(src1);
              ctl.alu_fun_sel  = ALU_PASS_A;
              ctl.mem_cs       = 1'b0;
              ctl.mem_wr       = 1'b1;
            end
            OP_BRA, OP_BEQ: begin
              if (op == OP_BRA || flag_z) begin
                ctl.mux_b_sel   = MUX_IMM;
                ctl.arf_r_sel   = ARF_EN_PC;
                ctl.arf_fun_sel = FUN_LOAD;
              end
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_system_ctrl.sv
// Hardwired fetch/decode/execute sequencer driving every ALUSystem control field.
//   state   | meaning
//   INIT    | clear RF and ARF (PC, AR, SP)
//   FETCH_L | mem[PC] -> IR low byte, PC++
//   FETCH_H | mem[PC] -> IR high byte, PC++
//   DECODE  | idle while IR_Out settles
//   EXEC    | one-cycle execute of the opcode
//   HALT    | absorbing; only Reset leaves
module alu_system_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter logic HALT_ON_UNDEF = 1'b1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IR_Out,
  input  logic [3:0]  ALU_ZCNO,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [1:0]  RF_FunSel,
  output logic [3:0]  RF_RSel,
  output logic [3:0]  RF_TSel,
  output logic [3:0]  ALU_FunSel,
  output logic [1:0]  ARF_OutASel,
  output logic [1:0]  ARF_OutBSel,
  output logic [1:0]  ARF_FunSel,
  output logic [3:0]  ARF_RSel,
  output logic        IR_LH,
  output logic        IR_Enable,
  output logic [1:0]  IR_Funsel,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic        Halted,
  output logic [2:0]  State
);

  state_t  state;
  state_t  state_next;
  opcode_t op;
  ctrl_t   ctl;
  logic    unused_flags;

  assign op           = opcode_t'(IR_Out[15:12]);
  assign unused_flags = ^ALU_ZCNO[2:0];

  always_ff @(posedge Clock) begin
    if (Reset) state <= S_INIT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = S_INIT;
    case (state)
      S_INIT:    state_next = S_FETCH_L;
      S_FETCH_L: state_next = S_FETCH_H;
      S_FETCH_H: state_next = S_DECODE;
      S_DECODE:  state_next = S_EXEC;
      S_EXEC: begin
        if (op == OP_HLT || (HALT_ON_UNDEF && is_undef(op))) state_next = S_HALT;
        else                                                  state_next = S_FETCH_L;
      end
      S_HALT:    state_next = S_HALT;
      default:   state_next = S_INIT;
    endcase
  end

  alu_ctrl_decode u_decode (
    .state      (state),
    .force_idle (Reset),
    .ir         (IR_Out),
    .flag_z     (ALU_ZCNO[3]),
    .ctl        (ctl)
  );

  assign RF_OutASel  = ctl.rf_outa_sel;
  assign RF_OutBSel  = ctl.rf_outb_sel;
  assign RF_FunSel   = ctl.rf_fun_sel;
  assign RF_RSel     = ctl.rf_r_sel;
  assign RF_TSel     = ctl.rf_t_sel;
  assign ALU_FunSel  = ctl.alu_fun_sel;
  assign ARF_OutASel = ctl.arf_outa_sel;
  assign ARF_OutBSel = ctl.arf_outb_sel;
  assign ARF_FunSel  = ctl.arf_fun_sel;
  assign ARF_RSel    = ctl.arf_r_sel;
  assign IR_LH       = ctl.ir_lh;
  assign IR_Enable   = ctl.ir_enable;
  assign IR_Funsel   = ctl.ir_fun_sel;
  assign Mem_WR      = ctl.mem_wr;
  assign Mem_CS      = ctl.mem_cs;
  assign MuxASel     = ctl.mux_a_sel;
  assign MuxBSel     = ctl.mux_b_sel;
  assign MuxCSel     = ctl.mux_c_sel;
  assign Halted      = (state == S_HALT);
  assign State       = state;

endmodule

// File: doc/alu_system_ctrl.md
Name: alu_system_ctrl

Overview:
- Hardwired control sequencer that sits directly upstream of ALUSystem and drives every one of its control fields each cycle.
- Fetches a 16-bit instruction as two bytes into the IR (low byte, then high byte), decodes it, executes it, and returns to fetch.
- Replaces the test-vector driver used for ALUSystem bring-up with real instruction sequencing.

Parameters:
- HALT_ON_UNDEF, 1, when 1 an undefined opcode enters HALT; when 0 it executes as NOP.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- IR_Out  in  16  ALUSystem IR contents.
- ALU_ZCNO  in  4  ALU flags {Z,C,N,O}; Z is bit 3.
- RF_OutASel, RF_OutBSel  out  3 each  RF read-port selects.
- RF_FunSel  out  2  RF function.
- RF_RSel, RF_TSel  out  4 each  RF write enables.
- ALU_FunSel  out  4  ALU operation.
- ARF_OutASel, ARF_OutBSel  out  2 each  ARF output selects; OutB is the memory address.
- ARF_FunSel  out  2  ARF function.
- ARF_RSel  out  4  ARF write enables.
- IR_LH, IR_Enable  out  1 each  IR byte select and enable.
- IR_Funsel  out  2  IR function.
- Mem_WR, Mem_CS  out  1 each  memory write; chip select is active-low.
- MuxASel, MuxBSel  out  2 each  mux selects.
- MuxCSel  out  1  mux select.
- Halted  out  1  high while in HALT.
- State  out  3  current state, for debug.

Behaviour:
- Instruction format:
  - [15:12] opcode, [11:10] DST, [9:8] SRC1, [7:6] SRC2, [7:0] IMM.
  - Register codes 0..3 map to R1..R4.
  - Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 NOT (of SRC1), 7 LDI, 8 LD, 9 ST, A BRA, B BEQ, C HLT; D-F are undefined.
- States:
  - INIT→FETCH_L→FETCH_H→DECODE→EXEC→FETCH_L.
  - HLT, or an undefined opcode with HALT_ON_UNDEF=1, goes EXEC→HALT.
  - HALT is absorbing; only Reset leaves it.
  - Encoding: INIT=0, FETCH_L=1, FETCH_H=2, DECODE=3, EXEC=4, HALT=5.
- Outputs are a combinational decode of the registered state and IR_Out.
- Idle output set (used in any state not listed below):
  - RF_RSel=RF_TSel=ARF_RSel=0, IR_Enable=0, Mem_CS=1, Mem_WR=0.
  - Every other field 0.
- Reset:
  - Takes effect at the clock edge, from any state including mid-instruction.
  - Next state is INIT and Halted=0; no partial write is issued in the reset cycle, because outputs are idle while Reset is high.
- INIT (1 cycle): RF_FunSel=CLR with RF_RSel=RF_TSel=4'b1111; ARF_FunSel=CLR with ARF_RSel=ALL, which clears PC, AR and SP.
- FETCH_L:
  - ARF_OutBSel=PC, Mem_CS=0, Mem_WR=0.
  - IR_Enable=1, IR_LH=0, IR_Funsel=LOAD.
  - ARF_RSel=PC with ARF_FunSel=INC.
- FETCH_H: identical to FETCH_L except IR_LH=1. PC therefore advances by 2 per instruction.
- DECODE: idle outputs; allows IR_Out to settle.
- EXEC, 1 cycle for every opcode:
  - ALU ops (1-6):
    - RF_OutASel=code(SRC1), RF_OutBSel=code(SRC2).
    - ALU_FunSel from the package table.
    - MuxASel=ALU, RF_FunSel=LOAD, RF_RSel=onehot(DST).
  - LDI: MuxASel=IMM, RF_FunSel=LOAD, RF_RSel=onehot(DST).
  - LD: ARF_OutBSel=AR, Mem_CS=0, MuxASel=MEM, load DST.
  - ST:
    - ARF_OutBSel=AR, RF_OutASel=code(SRC1).
    - ALU_FunSel=PASS_A, Mem_CS=0, Mem_WR=1.
  - BRA: MuxBSel=IMM, ARF_RSel=PC, ARF_FunSel=LOAD.
  - BEQ: same as BRA only when ALU_ZCNO[3]=1 in this cycle; otherwise idle.
  - NOP: idle outputs.
  - HLT: idle outputs; then HALT with Halted=1.
- No output may assert a write enable in DECODE or HALT.

Decomposition:
- Package alu_ctrl_pkg holds:
  - State encodings and the opcode enum.
  - ALU_FunSel codes.
  - RF/ARF/IR FunSel codes: CLR, LOAD, INC, DEC.
  - Register one-hots: R1=4'b1000, R2=0100, R3=0010, R4=0001.
  - RF_OutSel codes: R1..R4 = 3'b100..3'b111.
  - ARF codes for PC/AR/SP.
  - Mux select codes: ALU, MEM, IMM, ARF.
- One sub-module, alu_ctrl_decode: purely combinational, (state, IR_Out, Z) → output bundle.
- The top holds the state register and next-state logic.

Test Plan:
- Reset held for 2 cycles, then released:
  - State goes INIT→FETCH_L.
  - INIT shows RF_RSel=1111 and RF_FunSel=CLR.
  - FETCH_L shows Mem_CS=0, IR_LH=0, ARF PC INC.
- IR_Out=16'h1600 in EXEC (ADD R2←R3+R1): RF_OutASel=3'b110, RF_OutBSel=3'b100, ALU_FunSel=ADD, RF_RSel=4'b0100, RF_FunSel=LOAD.
- IR_Out=16'h7C5A (LDI R4←0x5A) then IR_Out=16'h9000 (ST R1):
  - LDI EXEC shows RF_RSel=0001, MuxASel=IMM.
  - ST EXEC shows Mem_WR=1, Mem_CS=0, ARF_OutBSel=AR.
- IR_Out=16'hB020 (BEQ 0x20):
  - With Z=0: ARF_RSel=0 in EXEC.
  - With Z=1: ARF_RSel=PC, ARF_FunSel=LOAD, MuxBSel=IMM.
- IR_Out=16'hC000 (HLT): HALT is reached and Halted=1 for 10 cycles with all enables 0; Reset is then accepted and the next state is INIT.
- Reset asserted during FETCH_H: the next cycle is INIT and no IR_Enable pulse follows. IR_Out=16'hE000 with HALT_ON_UNDEF=0 behaves as NOP and the next state is FETCH_L.
